// File: rtl/ssi_slave.sv
// SSI slave / encoder emulator: latches a position word on the master's first falling
// clock edge and shifts it out MSB first, one bit per rising edge, until the monoflop expires.
module ssi_slave #(
    parameter int dim      = 32,
    parameter int monoflop = 1500
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ssi_clk_in,
    output logic           ssi_data_out,
    input  logic [dim-1:0] data_in,
    output logic           busy,
    output logic           frame_done,
    output logic           short_frame
);

    localparam int BW = $clog2(dim + 1);
    localparam int MW = $clog2(monoflop + 1);

    localparam logic [BW-1:0] BCNT_FULL = BW'(dim);
    localparam logic [BW-1:0] BCNT_ONE  = BW'(1);
    localparam logic [MW-1:0] MCNT_LAST = MW'(monoflop - 1);
    localparam logic [MW-1:0] MCNT_ONE  = MW'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         state;
    logic           s1, s2, s3;
    logic [dim-1:0] shreg;
    logic [BW-1:0]  bcnt;
    logic [MW-1:0]  mcnt;
    logic           rise;
    logic           fall;

    // s1 is the metastability stage; edges are judged from s2/s3 only.
    assign fall = ~s2 & s3;
    assign rise = s2 & ~s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            s1           <= 1'b1;
            s2           <= 1'b1;
            s3           <= 1'b1;
            shreg        <= '0;
            bcnt         <= '0;
            mcnt         <= '0;
            ssi_data_out <= 1'b1;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            short_frame  <= 1'b0;
        end else begin
            s1          <= ssi_clk_in;
            s2          <= s1;
            s3          <= s2;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;

            case (state)
                IDLE: begin
                    ssi_data_out <= 1'b1;
                    busy         <= 1'b0;
                    if (fall) begin
                        shreg <= data_in;
                        bcnt  <= '0;
                        mcnt  <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (s2 && (mcnt == MCNT_LAST)) begin
                        state        <= IDLE;
                        ssi_data_out <= 1'b1;
                        busy         <= 1'b0;
                        frame_done   <= 1'b1;
                        short_frame  <= (bcnt < BCNT_FULL);
                        mcnt         <= '0;
                    end else if (rise) begin
                        mcnt <= '0;
                        if (bcnt < BCNT_FULL) begin
                            ssi_data_out <= shreg[dim-1];
                            shreg        <= {shreg[dim-2:0], 1'b0};
                            bcnt         <= bcnt + BCNT_ONE;
                        end else begin
                            // Master clocked past the word: pad with zeros.
                            ssi_data_out <= 1'b0;
                        end
                    end else if (s2) begin
                        mcnt <= mcnt + MCNT_ONE;
                    end else begin
                        mcnt <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ssi_slave.sv
// Bench for ssi_slave: table-driven frames, reset/idle corner sequences and random frames
// checked against a word-level model of the SSI transfer.
module tb_ssi_slave;

    localparam int DIM  = 8;
    localparam int MONO = 40;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ssi_clk_in = 1'b1;
    logic           ssi_data_out;
    logic [DIM-1:0] data_in = '0;
    logic           busy;
    logic           frame_done;
    logic           short_frame;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    ssi_slave #(.dim(DIM), .monoflop(MONO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ssi_clk_in   (ssi_clk_in),
        .ssi_data_out (ssi_data_out),
        .data_in      (data_in),
        .busy         (busy),
        .frame_done   (frame_done),
        .short_frame  (short_frame)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done) done_cnt++;

    typedef struct {
        logic [7:0]  word;
        int          nrise;
        logic [15:0] bits;
        bit          shrt;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Word-level model: bit i of a frame is the i-th MSB of the word, zeros past the word.
    function automatic logic [15:0] model_bits(input logic [DIM-1:0] word, input int nrise);
        logic [15:0] r;
        int b;
        r = '0;
        for (int i = 0; i < nrise; i++) begin
            b = (i < DIM) ? ((int'(word) >> (DIM - 1 - i)) & 1) : 0;
            r[nrise-1-i] = b[0];
        end
        return r;
    endfunction

    task automatic run_frame(input logic [DIM-1:0] word, input int nrise, input int half,
                             input logic [15:0] exp_bits, input bit exp_short, input string tag);
        int d0;
        int k;
        bit seen;
        data_in = word;
        tick(2);
        d0 = done_cnt;
        ssi_clk_in = 1'b0;
        tick(4);
        data_in = ~word;
        tick(4);
        for (int i = 0; i < nrise; i++) begin
            ssi_clk_in = 1'b1;
            tick(half);
            check($sformatf("%s_bit%0d", tag, i), 32'(ssi_data_out), 32'(exp_bits[nrise-1-i]));
            check($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
            if (i < nrise - 1) begin
                ssi_clk_in = 1'b0;
                tick(half);
            end
        end
        k = half;
        seen = 1'b0;
        while (!seen && k < MONO + 20) begin
            if (frame_done) seen = 1'b1;
            else begin
                tick(1);
                k++;
            end
        end
        check({tag, "_done_latency"}, 32'(k), 32'(MONO + 3));
        check({tag, "_short"}, 32'(short_frame), 32'(exp_short));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_idle_out"}, 32'(ssi_data_out), 32'd1);
        tick(1);
        check({tag, "_done_width"}, 32'(frame_done), 32'd0);
        check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int d0;
        logic [DIM-1:0] w;
        int n;
        int h;

        vecs[0] = '{word: 8'hA5, nrise: 8,  bits: 16'h00A5, shrt: 1'b0};
        vecs[1] = '{word: 8'hA5, nrise: 12, bits: 16'h0A50, shrt: 1'b0};
        vecs[2] = '{word: 8'hA5, nrise: 5,  bits: 16'h0014, shrt: 1'b1};
        vecs[3] = '{word: 8'hFF, nrise: 8,  bits: 16'h00FF, shrt: 1'b0};
        vecs[4] = '{word: 8'h3C, nrise: 8,  bits: 16'h003C, shrt: 1'b0};

        rst = 1'b1;
        tick(3);
        check("rst_out", 32'(ssi_data_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_short", 32'(short_frame), 32'd0);
        rst = 1'b0;
        tick(2);

        for (int v = 0; v < 5; v++)
            run_frame(vecs[v].word, vecs[v].nrise, 10, vecs[v].bits, vecs[v].shrt,
                      $sformatf("vec%0d", v));

        // Clock low/high transition hidden under reset, then a sub-cycle glitch: no frame.
        d0 = done_cnt;
        rst = 1'b1;
        ssi_clk_in = 1'b0;
        tick(4);
        ssi_clk_in = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(20);
        check("idle_rise_out", 32'(ssi_data_out), 32'd1);
        check("idle_rise_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2 ssi_clk_in = 1'b0;
        #3 ssi_clk_in = 1'b1;
        tick(10);
        check("glitch_out", 32'(ssi_data_out), 32'd1);
        check("glitch_busy", 32'(busy), 32'd0);
        check("idle_no_done", 32'(done_cnt - d0), 32'd0);

        // Reset mid-frame after three rises of 0x5A (output is 0 at that point).
        data_in = 8'h5A;
        tick(2);
        ssi_clk_in = 1'b0;
        tick(8);
        for (int i = 0; i < 3; i++) begin
            ssi_clk_in = 1'b1;
            tick(10);
            check($sformatf("pre_rst_bit%0d", i), 32'(ssi_data_out), 32'(model_bits(8'h5A, 3) >> (2 - i)) & 32'd1);
            if (i < 2) begin
                ssi_clk_in = 1'b0;
                tick(10);
            end
        end
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_out", 32'(ssi_data_out), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        d0 = done_cnt;
        tick(MONO + 20);
        check("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("post_rst_out", 32'(ssi_data_out), 32'd1);
        run_frame(8'h3C, 8, 10, 16'h003C, 1'b0, "after_rst");

        for (int r = 0; r < 8; r++) begin
            w = DIM'($urandom);
            n = $urandom_range(1, 12);
            h = $urandom_range(3, 12);
            run_frame(w, n, h, model_bits(w, n), (n < DIM), $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssi_slave.md
# ssi_slave

SSI transmitter (encoder emulator) that answers an SSI master by shifting out a parallel word, MSB first. It connects to an external SSI bus or a loopback path in simulation. It takes the master's clock, synchronises it into `clk`, and latches a position snapshot on the first falling edge of a frame. It drives one data bit per rising edge and returns to idle once the master's clock has stayed high for a monoflop timeout.

## Interface
Parameters:
- `dim`, 32: word width in bits, ≥ 2.
- `monoflop`, 1500: monoflop timeout in `clk` cycles (30 µs at 50 MHz). Must exceed the master's clock high half-period plus 3.

Ports:
- `clk` in 1: system clock, 50 MHz. All logic runs on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `ssi_clk_in` in 1: SSI clock from the master. Asynchronous; idles high.
- `ssi_data_out` out 1: SSI data line to the master. Idles high.
- `data_in` in `dim`: position word. Sampled only at the frame latch.
- `busy` out 1: high from the frame latch until the monoflop expires.
- `frame_done` out 1: one-cycle pulse when the monoflop expires.
- `short_frame` out 1: one-cycle pulse, coincident with `frame_done`, when fewer than `dim` bits were driven in the frame.

## Operation
- Synchroniser: 3-stage shift of `ssi_clk_in` (`s1`→`s2`→`s3`), all reset to 1.
  - fall = `~s2 & s3`; rise = `s2 & ~s3`. Only `s2` and `s3` feed logic.
- Internal state: shift register `shreg[dim-1:0]`; bit counter `bcnt`, saturating at `dim`; monoflop counter `mcnt`, ≥ ceil(log2(`monoflop`+1)) bits.
- States: IDLE, SHIFT.
- IDLE: `ssi_data_out`=1, `busy`=0.
  - On fall: `shreg`←`data_in`, `bcnt`←0, `mcnt`←0, `busy`←1, go to SHIFT.
  - A rise in IDLE is ignored.
- SHIFT:
  - On rise with `bcnt`<`dim`: `ssi_data_out`←`shreg[dim-1]`, `shreg`←{`shreg[dim-2:0]`,0}, `bcnt`←`bcnt`+1.
  - On rise with `bcnt`=`dim`: `ssi_data_out`←0 (tail zeros), `bcnt` holds.
  - On fall: no data change, `mcnt`←0.
  - While `s2`=0: `mcnt`←0.
  - While `s2`=1 and no rise: `mcnt`←`mcnt`+1.
  - When `mcnt`=`monoflop`-1 with `s2`=1:
    - go to IDLE; `ssi_data_out`←1; `busy`←0; `frame_done`←1 for one cycle.
    - `short_frame`←(`bcnt`<`dim`) for the same cycle.
- Simultaneous events in SHIFT: a rise in the expiry cycle cannot occur, because a rise clears `mcnt`. Expiry takes priority over counting.
- `data_in` changes after the latch have no effect until the next frame.
- A new fall in the same cycle IDLE is entered is not possible, since `s2`=1 there. The next fall starts a fresh frame.
- `rst` mid-frame: immediate return to IDLE on that edge. All outputs take reset values; no `frame_done` pulse.

## Timing
- Reset values:
  - `ssi_data_out`=1, `busy`=0, `frame_done`=0, `short_frame`=0.
  - `shreg`=0, `bcnt`=0, `mcnt`=0, `s1`..`s3`=1, state IDLE.
- Edge latency: a pin transition first sampled by `s1` at clk edge N is detected with `s2` at N+1. The resulting register update (`ssi_data_out`, `shreg`, `busy`) occurs at edge N+2.
- `data_in` is captured on the same edge that sets `busy`.
- The master must sample data on its falling edge, at least 3 `clk` cycles after driving the rising edge. At 50 MHz this limits the SSI clock to ≤ 8 MHz.
- Monoflop: `frame_done` asserts `monoflop` cycles after the last rise, as seen at `s2`.

## Test plan
- `dim`=8, `monoflop`=40, `data_in`=0xA5; master half-period 10 cycles, 1 fall then 8 rise/fall pairs, then clock held high:
  - `ssi_data_out` at each rise: 1,0,1,0,0,1,0,1.
  - `busy`=1 during the frame.
  - `frame_done`=1 for 1 cycle, 40 cycles after the last rise; `short_frame`=0; `ssi_data_out` returns to 1.
- Same setup with 12 rises: bits 9–12 are 0, and `frame_done` pulses once with `short_frame`=0.
- Same setup with only 5 rises: bits 1,0,1,0,0 are driven, then `frame_done` and `short_frame` pulse together.
- `data_in`=0xFF latched, then `data_in` changed to 0x00 after the first fall: output is 1,1,1,1,1,1,1,1.
- Rise in IDLE with no prior fall: `ssi_data_out` stays 1, `busy` stays 0.
- `rst` asserted after 3 rises: on the next edge `ssi_data_out`=1 and `busy`=0, with no `frame_done` pulse. A new frame with 0x3C then yields 0,0,1,1,1,1,0,0.
